collision_scheduler: RTL and testbench

Sequences the shared head-vs-object collision comparator once per snake move. On each `tick` it walks a small obstacle table, then optionally the body segments, through the comparator one object per cycle. It collects the registered results and reports a single verdict (obstacle hit, self hit, wall hit, food eaten) to the level/game FSM with a one-cycle `done` pulse.

---
 rtl/collision_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_collision_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - per-move collision scan sequencer for the shared head/object comparator
//
// Purpose: on each accepted tick, latches the head, food, body and obstacle count. It then
// presents each active obstacle-table entry to the comparator, one per cycle. When
// SNAKE_SELF_CHECK_EN is defined, body segments 1..4 follow the obstacles. The registered
// comparator results are folded into one verdict, and done pulses for one cycle.
//
// Optional feature macro: SNAKE_SELF_CHECK_EN (body segments appended to every scan).
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   tick                      snake moved, start a scan (only accepted in IDLE)
//   obs_count                 active obstacle count, clamped to MAX_OBS
//   head_x/head_y             head position
//   body_xy                   segments 1..4 packed {y4,x4,..,y1,x1}
//   food_x/food_y             food position
//   obs_wr_en/addr/x/y        obstacle table write port
//   obj_x/obj_y/obj_vld       object presented to the comparator
//   is_collision              comparator result, one cycle after obj_vld
//   busy, done                scan in progress; one-cycle completion pulse
//   hit_obs/hit_self/hit_wall/ate  verdict, held until next accepted tick
//   overrun                   sticky: tick arrived while busy
module collision_scheduler #(
  parameter int MAX_OBS  = 8,
  parameter int GRID_MAX = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  obs_count,
  input  logic [4:0]  head_x,
  input  logic [4:0]  head_y,
  input  logic [39:0] body_xy,
  input  logic [4:0]  food_x,
  input  logic [4:0]  food_y,
  input  logic        obs_wr_en,
  input  logic [3:0]  obs_wr_addr,
  input  logic [4:0]  obs_wr_x,
  input  logic [4:0]  obs_wr_y,
  output logic [4:0]  obj_x,
  output logic [4:0]  obj_y,
  output logic        obj_vld,
  input  logic        is_collision,
  output logic        busy,
  output logic        done,
  output logic        hit_obs,
  output logic        hit_self,
  output logic        hit_wall,
  output logic        ate,
  output logic        overrun
);

`ifdef SNAKE_SELF_CHECK_EN
  localparam logic [4:0] SELF_ITEMS = 5'd4;
`else
  localparam logic [4:0] SELF_ITEMS = 5'd0;
`endif
  localparam logic [3:0] MAX_OBS_L = 4'(MAX_OBS);
  localparam logic [4:0] GRID_LIM  = 5'(GRID_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;        // latched, clamped obstacle count
  logic [4:0]  n_items;    // total items this scan
  logic [4:0]  idx;        // item being issued
  logic        cap_pend;   // a comparator result is due this cycle
  logic        cap_obs;    // that result belongs to an obstacle (else a body segment)

  logic [4:0]  tab_x [MAX_OBS];
  logic [4:0]  tab_y [MAX_OBS];
  logic [4:0]  tab_rd_x;
  logic [4:0]  tab_rd_y;

  logic [3:0]  cnt_in;
  logic [4:0]  n_in;

  assign cnt_in = (obs_count > MAX_OBS_L) ? MAX_OBS_L : obs_count;
  assign n_in   = {1'b0, cnt_in} + SELF_ITEMS;

`ifdef SNAKE_SELF_CHECK_EN
  logic [39:0] body_lat;
  logic [4:0]  seg_idx;
  logic [9:0]  seg_yx;

  assign seg_idx = idx - {1'b0, cnt};

  always_comb begin
    case (seg_idx)
      5'd0:    seg_yx = body_lat[9:0];
      5'd1:    seg_yx = body_lat[19:10];
      5'd2:    seg_yx = body_lat[29:20];
      default: seg_yx = body_lat[39:30];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      body_lat <= '0;
    end else if (state == IDLE && tick) begin
      body_lat <= body_xy;
    end
  end
`else
  logic unused_body;
  assign unused_body = ^body_xy;
`endif

  // Obstacle table. Reads are combinational off the stored value, so a write
  // landing in the same cycle as an issue to that address issues the old entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < MAX_OBS; k++) begin
        tab_x[k] <= 5'd31;
        tab_y[k] <= 5'd31;
      end
    end else if (obs_wr_en && obs_wr_addr < MAX_OBS_L) begin
      for (int k = 0; k < MAX_OBS; k++) begin
        if (obs_wr_addr == 4'(k)) begin
          tab_x[k] <= obs_wr_x;
          tab_y[k] <= obs_wr_y;
        end
      end
    end
  end

  always_comb begin
    tab_rd_x = '0;
    tab_rd_y = '0;
    for (int k = 0; k < MAX_OBS; k++) begin
      if (idx == 5'(k)) begin
        tab_rd_x = tab_x[k];
        tab_rd_y = tab_y[k];
      end
    end
  end

  // Object presented to the comparator; zero outside SCAN.
  always_comb begin
    obj_vld = 1'b0;
    obj_x   = '0;
    obj_y   = '0;
    if (state == SCAN) begin
      obj_vld = 1'b1;
      if (idx < {1'b0, cnt}) begin
        obj_x = tab_rd_x;
        obj_y = tab_rd_y;
      end else begin
`ifdef SNAKE_SELF_CHECK_EN
        obj_x = seg_yx[4:0];
        obj_y = seg_yx[9:5];
`endif
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      n_items  <= '0;
      idx      <= '0;
      cap_pend <= 1'b0;
      cap_obs  <= 1'b0;
      hit_obs  <= 1'b0;
      hit_self <= 1'b0;
      hit_wall <= 1'b0;
      ate      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cap_pend <= 1'b0;

      // Result for the item issued last cycle; cap_pend is cleared by reset so
      // a result straggling in right after reset is dropped.
      if (cap_pend) begin
        if (cap_obs) begin
          hit_obs <= hit_obs | is_collision;
        end else begin
`ifdef SNAKE_SELF_CHECK_EN
          hit_self <= hit_self | is_collision;
`endif
        end
      end

      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            cnt      <= cnt_in;
            n_items  <= n_in;
            idx      <= '0;
            hit_obs  <= 1'b0;
            hit_self <= 1'b0;
            ate      <= (head_x == food_x) && (head_y == food_y);
            hit_wall <= (head_x > GRID_LIM) || (head_y > GRID_LIM);
            state    <= (n_in == 5'd0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          cap_pend <= 1'b1;
          cap_obs  <= (idx < {1'b0, cnt});
          if (idx == n_items - 5'd1) begin
            state <= DRAIN;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        DRAIN: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - directed self-checking bench for collision_scheduler
module tb_collision_scheduler;

`ifdef SNAKE_SELF_CHECK_EN
  localparam int S = 4;
`else
  localparam int S = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  obs_count;
  logic [4:0]  head_x, head_y;
  logic [39:0] body_xy;
  logic [4:0]  food_x, food_y;
  logic        obs_wr_en;
  logic [3:0]  obs_wr_addr;
  logic [4:0]  obs_wr_x, obs_wr_y;
  logic [4:0]  obj_x, obj_y;
  logic        obj_vld;
  logic        is_collision = 1'b0;
  logic        busy, done, hit_obs, hit_self, hit_wall, ate, overrun;

  int tests = 0;
  int fails = 0;

  logic       s_vld  [40];
  logic [4:0] s_x    [40];
  logic [4:0] s_y    [40];
  logic       s_busy [40];
  int done_at;
  int done_cnt;

  always #5 clk = ~clk;

  collision_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .obs_count(obs_count),
    .head_x(head_x), .head_y(head_y), .body_xy(body_xy),
    .food_x(food_x), .food_y(food_y),
    .obs_wr_en(obs_wr_en), .obs_wr_addr(obs_wr_addr),
    .obs_wr_x(obs_wr_x), .obs_wr_y(obs_wr_y),
    .obj_x(obj_x), .obj_y(obj_y), .obj_vld(obj_vld),
    .is_collision(is_collision),
    .busy(busy), .done(done), .hit_obs(hit_obs), .hit_self(hit_self),
    .hit_wall(hit_wall), .ate(ate), .overrun(overrun)
  );

  // Comparator model: registered head == object.
  always @(posedge clk) is_collision <= obj_vld && (obj_x == head_x) && (obj_y == head_y);

  function automatic logic [39:0] pack_body(input logic [4:0] x1, y1, x2, y2, x3, y3, x4, y4);
    return {y4, x4, y3, x3, y2, x2, y1, x1};
  endfunction

  task automatic wr_tab(input logic [3:0] a, input logic [4:0] x, input logic [4:0] y);
    obs_wr_en = 1'b1; obs_wr_addr = a; obs_wr_x = x; obs_wr_y = y;
    @(posedge clk); #1;
    obs_wr_en = 1'b0;
  endtask

  // Entered 1 time unit after a rising edge. Tick is sampled at edge T; cycle k
  // is the period after edge T+k-1.
  task automatic run_scan(input int cycles, input int tick2_at, input int rst_at,
                          input int wr_at, input logic [3:0] wa,
                          input logic [4:0] wx, input logic [4:0] wy);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    done_at = -1;
    done_cnt = 0;
    for (int k = 1; k <= cycles; k++) begin
      tick        = (k == tick2_at);
      rst         = !(k == rst_at);
      obs_wr_en   = (k == wr_at);
      obs_wr_addr = wa; obs_wr_x = wx; obs_wr_y = wy;
      @(negedge clk);
      s_vld[k] = obj_vld; s_x[k] = obj_x; s_y[k] = obj_y; s_busy[k] = busy;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      @(posedge clk); #1;
    end
    tick = 1'b0; rst = 1'b1; obs_wr_en = 1'b0;
  endtask

  function automatic int count_vld(input int cycles);
    int n = 0;
    for (int k = 1; k <= cycles; k++) if (s_vld[k]) n++;
    return n;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, obj_vld, obj_x, obj_y, hit_obs, hit_self, hit_wall, ate, overrun} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0",
               {busy, done, obj_vld, obj_x, obj_y, hit_obs, hit_self, hit_wall, ate, overrun});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ate;
    int nv;
    obs_count = 4'd0; head_x = 5'd5; head_y = 5'd5; food_x = 5'd5; food_y = 5'd5;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    run_scan(12, 0, 0, 0, 0, 0, 0);
    nv = count_vld(12);
    tests++;
    if (done_at != ((S == 0) ? 1 : S + 2)) begin
      fails++; $display("FAIL ate_done_at: got %0d expected %0d", done_at, (S == 0) ? 1 : S + 2);
    end
    tests++;
    if (nv != S) begin
      fails++; $display("FAIL ate_vld_count: got %0d expected %0d", nv, S);
    end
    tests++;
    if ({ate, hit_obs, hit_self, hit_wall} !== 4'b1000) begin
      fails++; $display("FAIL ate_verdict: got %b expected 1000", {ate, hit_obs, hit_self, hit_wall});
    end
  endtask

  task automatic test_obs_hit;
    wr_tab(0, 1, 1); wr_tab(1, 2, 2); wr_tab(2, 3, 3);
    obs_count = 4'd3; head_x = 5'd2; head_y = 5'd2; food_x = 5'd0; food_y = 5'd0;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    run_scan(14, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tests++;
      if (!(s_vld[k] === 1'b1 && s_x[k] == 5'(k) && s_y[k] == 5'(k) && s_busy[k] === 1'b1)) begin
        fails++;
        $display("FAIL obs_issue[%0d]: got vld=%b (%0d,%0d) busy=%b expected vld=1 (%0d,%0d) busy=1",
                 k, s_vld[k], s_x[k], s_y[k], s_busy[k], k, k);
      end
    end
    tests++;
    if (done_at != 5 + S || done_cnt != 1) begin
      fails++; $display("FAIL obs_done_at: got %0d (count %0d) expected %0d (count 1)", done_at, done_cnt, 5 + S);
    end
    tests++;
    if ({hit_obs, hit_self, hit_wall, ate} !== 4'b1000) begin
      fails++; $display("FAIL obs_verdict: got %b expected 1000", {hit_obs, hit_self, hit_wall, ate});
    end
  endtask

  task automatic test_self_hit;
    logic [4:0] ex [4];
    logic [4:0] ey [4];
    ex[0] = 8; ey[0] = 7; ex[1] = 8; ey[1] = 8; ex[2] = 7; ey[2] = 7; ex[3] = 6; ey[3] = 7;
    obs_count = 4'd2; head_x = 5'd7; head_y = 5'd7; food_x = 5'd0; food_y = 5'd0;
    body_xy = pack_body(ex[0], ey[0], ex[1], ey[1], ex[2], ey[2], ex[3], ey[3]);
    run_scan(14, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < S; j++) begin
      tests++;
      if (!(s_vld[3 + j] === 1'b1 && s_x[3 + j] == ex[j] && s_y[3 + j] == ey[j])) begin
        fails++;
        $display("FAIL self_seg[%0d]: got vld=%b (%0d,%0d) expected vld=1 (%0d,%0d)",
                 j + 1, s_vld[3 + j], s_x[3 + j], s_y[3 + j], ex[j], ey[j]);
      end
    end
    tests++;
    if (done_at != 4 + S) begin
      fails++; $display("FAIL self_done_at: got %0d expected %0d", done_at, 4 + S);
    end
    tests++;
    if (hit_self !== (S == 4) || hit_obs !== 1'b0) begin
      fails++; $display("FAIL self_verdict: got self=%b obs=%b expected self=%b obs=0", hit_self, hit_obs, S == 4);
    end
  endtask

  task automatic test_wall;
    obs_count = 4'd0; head_x = 5'd30; head_y = 5'd4; food_x = 5'd0; food_y = 5'd0;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    run_scan(10, 0, 0, 0, 0, 0, 0);
    tests++;
    if (hit_wall !== 1'b1 || done_at != ((S == 0) ? 1 : S + 2)) begin
      fails++; $display("FAIL wall_x30: got wall=%b done_at=%0d expected wall=1 done_at=%0d",
                        hit_wall, done_at, (S == 0) ? 1 : S + 2);
    end
    head_x = 5'd29; head_y = 5'd29;
    run_scan(10, 0, 0, 0, 0, 0, 0);
    tests++;
    if (hit_wall !== 1'b0) begin
      fails++; $display("FAIL wall_29_29: got %b expected 0", hit_wall);
    end
    head_x = 5'd3; head_y = 5'd31;
    run_scan(10, 0, 0, 0, 0, 0, 0);
    tests++;
    if (hit_wall !== 1'b1) begin
      fails++; $display("FAIL wall_y31: got %b expected 1", hit_wall);
    end
  endtask

  // obs_count 15 clamps to 8; address 8 is out of range; entry 0 rewritten while being issued.
  task automatic test_clamp_and_write;
    int nv;
    wr_tab(7, 12, 12);
    wr_tab(8, 4, 4);
    obs_count = 4'd15; head_x = 5'd4; head_y = 5'd4; food_x = 5'd0; food_y = 5'd0;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    run_scan(20, 0, 0, 1, 4'd0, 5'd4, 5'd4);
    nv = count_vld(20);
    tests++;
    if (nv != 8 + S) begin
      fails++; $display("FAIL clamp_vld_count: got %0d expected %0d", nv, 8 + S);
    end
    tests++;
    if (s_x[1] != 5'd1 || s_y[1] != 5'd1) begin
      fails++; $display("FAIL write_same_cycle_old: got (%0d,%0d) expected (1,1)", s_x[1], s_y[1]);
    end
    tests++;
    if (s_x[8] != 5'd12 || s_y[8] != 5'd12 || s_x[5] != 5'd31) begin
      fails++; $display("FAIL clamp_entries: got e7=(%0d,%0d) e4x=%0d expected e7=(12,12) e4x=31",
                        s_x[8], s_y[8], s_x[5]);
    end
    tests++;
    if (hit_obs !== 1'b0 || done_at != 10 + S) begin
      fails++; $display("FAIL clamp_verdict: got obs=%b done_at=%0d expected obs=0 done_at=%0d",
                        hit_obs, done_at, 10 + S);
    end
  endtask

  task automatic test_overrun;
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_initial: got %b expected 0", overrun);
    end
    obs_count = 4'(6 - S); head_x = 5'd20; head_y = 5'd20; food_x = 5'd0; food_y = 5'd0;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    run_scan(14, 2, 0, 0, 0, 0, 0);
    tests++;
    if (done_cnt != 1 || done_at != 8 || overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_scan: got done_cnt=%0d done_at=%0d ovr=%b expected 1, 8, 1",
                        done_cnt, done_at, overrun);
    end
    obs_count = 4'd0;
    run_scan(10, 0, 0, 0, 0, 0, 0);
    tests++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid;
    // Entry 1 is (2,2) so the result for the item issued in the reset cycle would hit.
    obs_count = 4'd3; head_x = 5'd2; head_y = 5'd2; food_x = 5'd2; food_y = 5'd2;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    run_scan(10, 0, 2, 0, 0, 0, 0);
    tests++;
    if (s_vld[3] !== 1'b0 || s_busy[3] !== 1'b0 || s_x[3] != 5'd0 || s_y[3] != 5'd0 || done_cnt != 0) begin
      fails++; $display("FAIL reset_mid_outputs: got vld=%b busy=%b (%0d,%0d) dones=%0d expected all 0",
                        s_vld[3], s_busy[3], s_x[3], s_y[3], done_cnt);
    end
    tests++;
    if ({hit_obs, hit_self, hit_wall, ate, overrun} !== 5'd0) begin
      fails++; $display("FAIL reset_mid_verdict: got %b expected 00000", {hit_obs, hit_self, hit_wall, ate, overrun});
    end
    head_x = 5'd0; head_y = 5'd0; food_x = 5'd9;
    run_scan(12, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tests++;
      if (s_vld[k] !== 1'b1 || s_x[k] != 5'd31 || s_y[k] != 5'd31) begin
        fails++; $display("FAIL table_reinit[%0d]: got vld=%b (%0d,%0d) expected vld=1 (31,31)",
                          k - 1, s_vld[k], s_x[k], s_y[k]);
      end
    end
  endtask

  // Ticks exactly N+3 cycles apart are both accepted without overrun.
  task automatic test_back_to_back;
    obs_count = 4'd3; head_x = 5'd1; head_y = 5'd2; food_x = 5'd0; food_y = 5'd0;
    body_xy = pack_body(10, 10, 11, 10, 12, 10, 13, 10);
    for (int r = 0; r < 2; r++) begin
      run_scan(3 + S + 2, 0, 0, 0, 0, 0, 0);
      tests++;
      if (done_cnt != 1 || done_at != 5 + S) begin
        fails++; $display("FAIL back_to_back[%0d]: got done_cnt=%0d done_at=%0d expected 1, %0d",
                          r, done_cnt, done_at, 5 + S);
      end
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL back_to_back_overrun: got %b expected 0", overrun);
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; obs_count = '0; head_x = '0; head_y = '0; body_xy = '0;
    food_x = '0; food_y = '0; obs_wr_en = 1'b0; obs_wr_addr = '0; obs_wr_x = '0; obs_wr_y = '0;
    @(posedge clk); #1;
    test_reset;
    test_ate;
    test_obs_hit;
    test_self_hit;
    test_wall;
    test_clamp_and_write;
    test_overrun;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
